// File: rtl/fp_pkg.sv
// Shared types and helpers for the fp_addsub floating-point datapath:
// FSM state enum, exception flag bit positions and width-derived helpers.
package fp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  localparam int unsigned INVALID   = 3;
  localparam int unsigned OVERFLOW  = 2;
  localparam int unsigned UNDERFLOW = 1;
  localparam int unsigned INEXACT   = 0;

  // Guard, round and sticky bits carried below the mantissa LSB.
  localparam int unsigned GRS_W = 3;

  function automatic int unsigned fp_width(input int unsigned ew, input int unsigned mw);
    return 1 + ew + mw;
  endfunction

  // Canonical quiet NaN, right-aligned in a wide vector; callers slice to W bits.
  function automatic logic [127:0] fp_qnan(input int unsigned ew, input int unsigned mw);
    logic [127:0] r;
    r = ((128'(1) << ew) - 128'(1)) << mw;
    r = r | (128'(1) << (mw - 1));
    return r;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module fp_lzc #(
  parameter int unsigned WIDTH = 27
) (
  input  logic [WIDTH-1:0]         value,
  output logic [$clog2(WIDTH+1)-1:0] count
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] v;
  logic             found;

  always_comb begin
    count = '0;
    found = 1'b0;
    v     = value;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found) begin
        if (v[WIDTH-1]) begin
          found = 1'b1;
        end else begin
          count = count + CW'(1);
          v     = v << 1;
        end
      end
    end
  end

endmodule

// File: rtl/fp_addsub.sv
// fp_addsub: multi-cycle IEEE-754 add/subtract, round-to-nearest-even, fixed 6-cycle latency.
// Define FP_SUBNORMAL_EN for gradual underflow; otherwise subnormals are flushed to zero.
module fp_addsub
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 op,
  input  logic                 available,
  output logic                 busy,
  output logic [EXP_W+MAN_W:0] sum,
  output logic                 done,
  output logic [3:0]           exception
);
  localparam int unsigned W   = fp_width(EXP_W, MAN_W);
  localparam int unsigned AW  = MAN_W + 1 + GRS_W;
  localparam int unsigned SW  = AW + 1;
  localparam int unsigned LZW = $clog2(AW + 1);
  localparam logic signed [EXP_W+1:0] EONE = (EXP_W+2)'(1);
  localparam logic signed [EXP_W+1:0] EMAX = (EXP_W+2)'((1 << EXP_W) - 1);
`ifdef FP_SUBNORMAL_EN
  localparam bit FLUSH = 1'b0;
`else
  localparam bit FLUSH = 1'b1;
`endif

  state_t                  state;
  logic [W-1:0]            ra, rb, spec_res;
  logic                    sx, sy, rs, spec;
  logic [3:0]              spec_exc;
  logic [EXP_W-1:0]        ex, ey;
  logic [MAN_W:0]          mx, my;
  logic [AW-1:0]           xal, yal, nrm;
  logic [SW-1:0]           acc;
  logic signed [EXP_W+1:0] re, ne;

  // UNPACK: classify, restore hidden bit, order by magnitude.
  logic [EXP_W-1:0] ea, eb, ua_e, ub_e;
  logic [MAN_W:0]   ua_m, ub_m;
  logic             a_nan, b_nan, a_inf, b_inf, a_big, u_spec;
  logic [W-1:0]     u_sres;
  logic [3:0]       u_sexc;

  always_comb begin
    ea    = ra[W-2:MAN_W];
    eb    = rb[W-2:MAN_W];
    a_nan = (&ea) & (|ra[MAN_W-1:0]);
    b_nan = (&eb) & (|rb[MAN_W-1:0]);
    a_inf = (&ea) & ~(|ra[MAN_W-1:0]);
    b_inf = (&eb) & ~(|rb[MAN_W-1:0]);
`ifdef FP_SUBNORMAL_EN
    ua_e = (|ea) ? ea : EXP_W'(1);
    ub_e = (|eb) ? eb : EXP_W'(1);
    ua_m = {|ea, ra[MAN_W-1:0]};
    ub_m = {|eb, rb[MAN_W-1:0]};
`else
    ua_e = ea;
    ub_e = eb;
    ua_m = (|ea) ? {1'b1, ra[MAN_W-1:0]} : '0;
    ub_m = (|eb) ? {1'b1, rb[MAN_W-1:0]} : '0;
`endif
    a_big  = {ua_e, ua_m} >= {ub_e, ub_m};
    u_spec = 1'b1;
    u_sres = '0;
    u_sexc = '0;
    if (a_nan | b_nan | (a_inf & b_inf & (ra[W-1] != rb[W-1]))) begin
      u_sres          = W'(fp_qnan(EXP_W, MAN_W));
      u_sexc[INVALID] = 1'b1;
    end else if (a_inf) begin
      u_sres = ra;
    end else if (b_inf) begin
      u_sres = rb;
    end else begin
      u_spec = 1'b0;
    end
  end

  // ALIGN: distances beyond the GRS window collapse into sticky.
  logic [31:0]     dz;
  logic [2*AW-1:0] wide;
  logic [AW-1:0]   al_y;

  always_comb begin
    dz   = 32'(ex - ey);
    wide = {my, {GRS_W{1'b0}}, {AW{1'b0}}} >> dz;
    if (dz > AW - 1) begin
      al_y = {{(AW-1){1'b0}}, |my};
    end else begin
      al_y    = wide[2*AW-1:AW];
      al_y[0] = al_y[0] | (|wide[AW-1:0]);
    end
  end

  logic [SW-1:0] add_n;
  always_comb begin
    add_n = (sx == sy) ? ({1'b0, xal} + {1'b0, yal}) : ({1'b0, xal} - {1'b0, yal});
  end

  // NORM
  logic [LZW-1:0]          lz;
  logic [AW-1:0]           nrm_n;
  logic signed [EXP_W+1:0] ne_n;
  int                      lzi, shi;
`ifdef FP_SUBNORMAL_EN
  int                      lim;
`endif

  fp_lzc #(.WIDTH(AW)) u_lzc (.value(acc[AW-1:0]), .count(lz));

  always_comb begin
    lzi   = 32'(lz);
    shi   = lzi;
    nrm_n = '0;
    ne_n  = re;
`ifdef FP_SUBNORMAL_EN
    lim = 32'(re) - 1;
    if (lzi > lim) shi = lim;
`endif
    if (acc[SW-1]) begin
      nrm_n    = acc[SW-1:1];
      nrm_n[0] = acc[1] | acc[0];
      ne_n     = re + EONE;
    end else begin
      nrm_n = acc[AW-1:0] << shi;
      ne_n  = re - (EXP_W+2)'(shi);
    end
  end

  // ROUND and final packing; special-case results bypass the datapath here.
  logic                    up, inex, tiny;
  logic [MAN_W+1:0]        mr;
  logic [MAN_W:0]          mant;
  logic [EXP_W-1:0]        efld;
  logic signed [EXP_W+1:0] ef;
  logic [W-1:0]            res_n;
  logic [3:0]              exc_n;

  always_comb begin
    inex = |nrm[2:0];
    up   = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
    mr   = {1'b0, nrm[AW-1:GRS_W]} + (MAN_W+2)'(up);
    mant = mr[MAN_W+1] ? mr[MAN_W+1:1] : mr[MAN_W:0];
    ef   = mr[MAN_W+1] ? ne + EONE : ne;
    efld = mant[MAN_W] ? ef[EXP_W-1:0] : '0;
`ifdef FP_SUBNORMAL_EN
    tiny = ~nrm[AW-1];
`else
    tiny = ne < EONE;
`endif
    res_n = '0;
    exc_n = '0;
    if (spec) begin
      res_n = spec_res;
      exc_n = spec_exc;
    end else if (nrm == '0) begin
      res_n = {rs, {(W-1){1'b0}}};
    end else if (FLUSH && tiny) begin
      res_n            = {rs, {(W-1){1'b0}}};
      exc_n[UNDERFLOW] = 1'b1;
      exc_n[INEXACT]   = 1'b1;
    end else if (ef >= EMAX) begin
      res_n           = {rs, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      exc_n[OVERFLOW] = 1'b1;
      exc_n[INEXACT]  = 1'b1;
    end else begin
      res_n            = {rs, efld, mant[MAN_W-1:0]};
      exc_n[INEXACT]   = inex;
      exc_n[UNDERFLOW] = tiny & inex;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      sum       <= '0;
      exception <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (available) begin
            ra    <= a;
            rb    <= {b[W-1] ^ op, b[W-2:0]};
            busy  <= 1'b1;
            state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          sx       <= a_big ? ra[W-1] : rb[W-1];
          sy       <= a_big ? rb[W-1] : ra[W-1];
          ex       <= a_big ? ua_e : ub_e;
          ey       <= a_big ? ub_e : ua_e;
          mx       <= a_big ? ua_m : ub_m;
          my       <= a_big ? ub_m : ua_m;
          spec     <= u_spec;
          spec_res <= u_sres;
          spec_exc <= u_sexc;
          state    <= S_ALIGN;
        end
        S_ALIGN: begin
          xal   <= {mx, {GRS_W{1'b0}}};
          yal   <= al_y;
          state <= S_ADD;
        end
        S_ADD: begin
          acc   <= add_n;
          rs    <= (add_n == '0) ? (sx & sy) : sx;
          re    <= {2'b00, ex};
          state <= S_NORM;
        end
        S_NORM: begin
          nrm   <= nrm_n;
          ne    <= ne_n;
          state <= S_ROUND;
        end
        S_ROUND: begin
          sum       <= res_n;
          exception <= exc_n;
          done      <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp_addsub.md
# fp_addsub

Parametrised, multi-cycle IEEE-754 binary floating-point adder/subtractor with configurable exponent and mantissa widths and an add/subtract mode input. It uses round-to-nearest-even and reports exception flags. It is the next generation of the single-precision adder. It keeps the `available`/`done` start/complete handshake, has a fixed latency, and sits between operand registers and the result writeback in the FP datapath.

## Interface
- `EXP_W`, default 8: exponent field width (≥ 3).
- `MAN_W`, default 23: stored mantissa width, without the hidden bit (≥ 2).
- Derived: `W = 1 + EXP_W + MAN_W`; `BIAS = 2^(EXP_W-1) - 1`.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `a`, `b`  in  W each: operands, packed as {sign, exponent, mantissa}.
- `op`  in  1: 0 computes a+b; 1 computes a−b.
- `available`  in  1: start request, sampled only in IDLE.
- `busy`  out  1: high from the cycle after capture through the DONE state.
- `sum`  out  W: result; holds its value until the next DONE.
- `done`  out  1: one-cycle pulse when `sum` and `exception` are valid.
- `exception`  out  4: {invalid, overflow, underflow, inexact}; valid with `done` and held afterwards.

## Operation
- States and transitions: IDLE → UNPACK → ALIGN → ADD → NORM → ROUND → DONE → IDLE. Every non-IDLE state lasts exactly one cycle.
- IDLE: `available`=1 captures `a`, `b`, `op`, and `b` has its sign inverted when `op`=1. While not in IDLE, `available` is ignored and no request is queued.
- UNPACK:
  - Detect zero, subnormal, infinity and NaN.
  - Restore the hidden bit.
  - Swap operands so the larger magnitude is the first operand.
- ALIGN: shift the smaller significand right by the exponent difference, through guard, round and sticky bits. A difference greater than MAN_W+3 collapses the significand into sticky.
- ADD: add or subtract significands according to the effective sign. Width is MAN_W+5 bits (carry, hidden, mantissa, G, R, S).
- NORM:
  - On carry-out, shift right by 1 and increment the exponent.
  - Otherwise, left-shift by the leading-zero count from `fp_lzc`, limited so the exponent does not go below the minimum.
- ROUND:
  - Round to nearest even: round up when G & (R | S | LSB).
  - A mantissa overflow from rounding renormalises and increments the exponent.
  - Exponent reaching all-ones gives ±infinity with overflow and inexact set.
- Special cases, resolved in UNPACK and carried to DONE:
  - Any NaN input, or (+inf) + (−inf) effective: canonical quiet NaN (sign 0, exponent all-ones, mantissa MSB 1, remaining bits 0), invalid=1.
  - inf ± finite: that infinity, no flags.
  - Exact zero result from nonzero operands: +0.
  - (−0) + (−0): −0.
- Flags: `inexact` = any nonzero G/R/S discarded at rounding. `underflow` = result tiny and inexact.

## Timing
- Capture edge is edge T, with `available`=1 in IDLE. `done`=1 during cycle T+6, and the result is also visible on `sum` in that cycle.
- Latency is fixed at 6 cycles regardless of operands or special case.
- Back-to-back throughput: one operation per 7 cycles. `available` asserted in the cycle after `done` is accepted.
- Reset values: state IDLE, `sum`=0, `done`=0, `busy`=0, `exception`=0.
- Reset mid-operation: return to IDLE on that edge, discard the operation, no `done` pulse. `sum` and `exception` clear to 0.
- `available` and `reset` high on the same edge: reset wins and nothing is captured.

## Configuration
- `FP_SUBNORMAL_EN` defined: subnormal inputs are decoded with exponent 1 and no hidden bit. Results below the normal range are denormalised (gradual underflow) and rounded.
- `FP_SUBNORMAL_EN` undefined:
  - Subnormal inputs are treated as zero of the same sign.
  - Any result below the smallest normal flushes to zero of the result sign, with underflow=1 and inexact=1.
  - Cost: the NORM shift limit is removed.

## Structure
- Package `fp_pkg` contains:
  - The state enum.
  - Flag bit-index constants (INVALID=3, OVERFLOW=2, UNDERFLOW=1, INEXACT=0).
  - Width-derived localparam helpers.
  - A function returning the canonical NaN for given EXP_W/MAN_W.
- Sub-module `fp_lzc #(WIDTH)`: combinational leading-zero counter used by NORM.

## Test plan
- 0x40400000 + 0x40800000, `op`=0 → `sum`=0x40E00000 (7.0), `exception`=0. `done` is exactly 6 cycles after capture and `busy` is high for cycles T+1..T+6.
- 0x3F800000 − 0x3F800000 (`op`=1) → 0x00000000. Separately, 0x80000000 + 0x80000000 → 0x80000000.
- 0x3F800000 + 0x33800000 (tie) → 0x3F800000 with inexact=1. 0x3F800001 + 0x33800000 → 0x3F800002 with inexact=1.
- 0x7F800000 + 0xFF800000 → 0x7FC00000 with invalid=1. 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000 with overflow=1 and inexact=1.
- 0x00000001 + 0x00000001: with `FP_SUBNORMAL_EN` → 0x00000002, flags 0. Without it → 0x00000000.
- Assert `reset` at T+3 of an operation → no `done` pulse and all outputs 0. A new `available` at T+5 is accepted and produces a correct result. Repeat with `EXP_W`=5, `MAN_W`=10: 0x4200 + 0x4400 → 0x4700.
